// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file constants and arbitration types for the writeback arbiter.
// The reg_file and rf_wb_arbiter both take their widths from here.
package rf_wb_arbiter_pkg;

    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        GRANT_P0 = 1'b0,
        GRANT_P1 = 1'b1
    } grant_port_e;

    function automatic grant_port_e other_port(input grant_port_e p);
        return (p == GRANT_P0) ? GRANT_P1 : GRANT_P0;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Small per-requester writeback FIFO with a flattened entry view, so the parent
// can see every buffered destination register when it builds the pending vector.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37,
    parameter int AW    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [W-1:0]        push_data,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output logic [W-1:0]        head,
    output logic [DEPTH-1:0]    entry_valid,
    output logic [DEPTH*AW-1:0] entry_addr
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]  count;
    logic [PW-1:0] offset;

    // Extra pointer bit separates full from empty when the low bits match.
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[PW-1:0]];
    assign count = wr_ptr_q - rd_ptr_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[PW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // A slot is live when its distance from the read pointer is below occupancy.
    always_comb begin
        offset      = '0;
        entry_valid = '0;
        entry_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset                 = PW'(i) - rd_ptr_q[PW-1:0];
            entry_valid[i]         = ({1'b0, offset} < count);
            entry_addr[i*AW +: AW] = mem_q[i][W-1 -: AW];
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port between the ALU and load writeback paths,
// and exports which registers still have a write in flight for hazard stalls.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p0_valid,
    output logic                p0_ready,
    input  logic [AW-1:0]       p0_addr,
    input  logic [DW-1:0]       p0_data,
    input  logic                p1_valid,
    output logic                p1_ready,
    input  logic [AW-1:0]       p1_addr,
    input  logic [DW-1:0]       p1_data,
    output logic                we3,
    output logic [AW-1:0]       a3,
    output logic [DW-1:0]       wd3,
    output logic [NUM_REGS-1:0] pending,
    output logic                idle
);

    localparam int W = AW + DW;

    logic                f0_full, f0_empty, f1_full, f1_empty;
    logic [W-1:0]        f0_head, f1_head;
    logic [DEPTH-1:0]    f0_entry_valid, f1_entry_valid;
    logic [DEPTH*AW-1:0] f0_entry_addr, f1_entry_addr;
    logic                push0, push1, pop0, pop1;

    logic                grant_valid;
    grant_port_e         grant_port;
    logic [W-1:0]        grant_head;

    grant_port_e         last_grant_q, last_grant_d;
    logic                we3_q, we3_d;
    logic [AW-1:0]       a3_q, a3_d;
    logic [DW-1:0]       wd3_q, wd3_d;
    logic                hit;

    assign p0_ready = !f0_full;
    assign p1_ready = !f1_full;

    // Writes to x0 complete the handshake but are never buffered.
    assign push0 = p0_valid && !f0_full && (p0_addr != '0);
    assign push1 = p1_valid && !f1_full && (p1_addr != '0);

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (W),
        .AW    (AW)
    ) u_fifo0 (
        .clk         (clk),
        .rst         (rst),
        .push        (push0),
        .push_data   ({p0_addr, p0_data}),
        .pop         (pop0),
        .full        (f0_full),
        .empty       (f0_empty),
        .head        (f0_head),
        .entry_valid (f0_entry_valid),
        .entry_addr  (f0_entry_addr)
    );

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (W),
        .AW    (AW)
    ) u_fifo1 (
        .clk         (clk),
        .rst         (rst),
        .push        (push1),
        .push_data   ({p1_addr, p1_data}),
        .pop         (pop1),
        .full        (f1_full),
        .empty       (f1_empty),
        .head        (f1_head),
        .entry_valid (f1_entry_valid),
        .entry_addr  (f1_entry_addr)
    );

    // Round robin only matters under contention; a lone requester always wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = GRANT_P0;
        if (!f0_empty && !f1_empty) begin
            grant_valid = 1'b1;
            grant_port  = other_port(last_grant_q);
        end else if (!f0_empty) begin
            grant_valid = 1'b1;
            grant_port  = GRANT_P0;
        end else if (!f1_empty) begin
            grant_valid = 1'b1;
            grant_port  = GRANT_P1;
        end
    end

    assign pop0       = grant_valid && (grant_port == GRANT_P0);
    assign pop1       = grant_valid && (grant_port == GRANT_P1);
    assign grant_head = (grant_port == GRANT_P1) ? f1_head : f0_head;

    always_comb begin
        last_grant_d = last_grant_q;
        we3_d        = grant_valid;
        a3_d         = a3_q;
        wd3_d        = wd3_q;
        if (grant_valid) begin
            last_grant_d = grant_port;
            a3_d         = grant_head[W-1 -: AW];
            wd3_d        = grant_head[DW-1:0];
        end
    end

    // Resetting last_grant to port 1 hands port 0 the first contended grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_P1;
            we3_q        <= 1'b0;
            a3_q         <= '0;
            wd3_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            we3_q        <= we3_d;
            a3_q         <= a3_d;
            wd3_q        <= wd3_d;
        end
    end

    assign we3 = we3_q;
    assign a3  = a3_q;
    assign wd3 = wd3_q;

    always_comb begin
        pending = '0;
        hit     = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            hit = we3_q && (a3_q == AW'(r));
            for (int i = 0; i < DEPTH; i++) begin
                hit = hit ||
                      (f0_entry_valid[i] && (f0_entry_addr[i*AW +: AW] == AW'(r))) ||
                      (f1_entry_valid[i] && (f1_entry_addr[i*AW +: AW] == AW'(r)));
            end
            pending[r] = hit;
        end
    end

    assign idle = f0_empty && f1_empty && !we3_q;

endmodule
